// File: rtl/mac_tile_dual_if.sv
// Neighbour bus of one dual-mode MAC tile: west/north inputs, east/south outputs.
// The tile connects through the slave modport; whatever drives the west and
// north edges (neighbour tiles or a bench) connects through the master modport.
interface mac_tile_dual_if #(
   parameter int bw      = 4,
   parameter int psum_bw = 16
);
   logic signed [bw-1:0]      in_w;
   logic        [3:0]         inst_w;
   logic signed [psum_bw-1:0] in_n;
   logic signed [bw-1:0]      out_e;
   logic        [3:0]         inst_e;
   logic signed [psum_bw-1:0] out_s;

   modport master (
      output in_w, inst_w, in_n,
      input  out_e, inst_e, out_s
   );

   modport slave (
      input  in_w, inst_w, in_n,
      output out_e, inst_e, out_s
   );
endinterface

// File: rtl/mac_tile_dual.sv
// Dual-mode systolic MAC tile.
// Weight-stationary mode: a weight is loaded once, then every exec adds
// in_w * weight to the psum arriving from the north and sends it south.
// Output-stationary mode: the weight arrives on in_n, products accumulate
// locally and are drained south on request, chaining the north tiles' results.
// inst bits: [0] load, [1] exec, [2] os select, [3] drain / weight clear.
// Priority each cycle is exec > drain/wclr > load.
module mac_tile_dual #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int SAT     = 0
) (
   input logic           clk,
   input logic           reset,
   mac_tile_dual_if.slave tile
);

   typedef enum logic [1:0] {
      S_EMPTY    = 2'd0,
      S_LOADED   = 2'd1,
      S_OS_ACC   = 2'd2,
      S_OS_DRAIN = 2'd3
   } state_t;

   localparam logic signed [psum_bw-1:0] PSUM_MAX = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic signed [psum_bw-1:0] PSUM_MIN = {1'b1, {(psum_bw-1){1'b0}}};

   // Registered state and outputs
   state_t                    state_q;
   logic signed [bw-1:0]      b_q;
   logic signed [psum_bw-1:0] acc_q;
   logic signed [psum_bw-1:0] out_s_q;
   logic signed [bw-1:0]      out_e_q;
   logic        [3:0]         inst_e_q;

   // Instruction decode
   logic inst_load;
   logic inst_exec;
   logic inst_os;
   logic inst_drain;

   assign inst_load  = tile.inst_w[0];
   assign inst_exec  = tile.inst_w[1];
   assign inst_os    = tile.inst_w[2];
   assign inst_drain = tile.inst_w[3];

   // Two's-complement adder of psum width: wraps, or clamps when SAT is set.
   function automatic logic signed [psum_bw-1:0] add_fit(
      input logic signed [psum_bw-1:0] a,
      input logic signed [psum_bw-1:0] b
   );
      logic signed [psum_bw:0] sum;
      sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if ((SAT != 0) && (sum[psum_bw] != sum[psum_bw-1])) begin
         return sum[psum_bw] ? PSUM_MIN : PSUM_MAX;
      end
      return sum[psum_bw-1:0];
   endfunction

   // Operands are sign-extended to the full product width before multiplying,
   // so the product is exact; it is then sign-extended to psum width.
   logic signed [bw-1:0]        wt_os;
   logic signed [2*bw-1:0]      w_ext;
   logic signed [2*bw-1:0]      b_ext;
   logic signed [2*bw-1:0]      wt_ext;
   logic signed [2*bw-1:0]      prod_ws;
   logic signed [2*bw-1:0]      prod_os;
   logic signed [psum_bw-1:0]   prod_ws_p;
   logic signed [psum_bw-1:0]   prod_os_p;
   logic signed [psum_bw-1:0]   wt_os_p;
   logic signed [psum_bw-1:0]   acc_base;
   logic signed [psum_bw-1:0]   ws_sum_d;
   logic signed [psum_bw-1:0]   os_sum_d;

   assign wt_os     = tile.in_n[bw-1:0];
   assign w_ext     = (2*bw)'(tile.in_w);
   assign b_ext     = (2*bw)'(b_q);
   assign wt_ext    = (2*bw)'(wt_os);
   assign prod_ws   = w_ext * b_ext;
   assign prod_os   = w_ext * wt_ext;
   assign prod_ws_p = psum_bw'(prod_ws);
   assign prod_os_p = psum_bw'(prod_os);
   assign wt_os_p   = psum_bw'(wt_os);

   // A fresh output-stationary pass after a drain starts from zero.
   assign acc_base  = (state_q == S_OS_DRAIN) ? '0 : acc_q;
   assign ws_sum_d  = add_fit(tile.in_n, prod_ws_p);
   assign os_sum_d  = add_fit(acc_base, prod_os_p);

   // A load is consumed only when it wins priority and the tile has room for
   // a weight; otherwise the load bit is forwarded east to the next tile.
   logic load_consume;
   logic load_fwd;

   assign load_consume = inst_load && !inst_exec && !inst_drain &&
                         ((state_q == S_EMPTY) || (state_q == S_OS_DRAIN));
   assign load_fwd     = inst_load && !load_consume;

   // Tile FSM with registered outputs; reset clears weight, accumulator and outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_EMPTY;
         b_q      <= '0;
         acc_q    <= '0;
         out_s_q  <= '0;
         out_e_q  <= '0;
         inst_e_q <= '0;
      end else begin
         out_e_q  <= tile.in_w;
         inst_e_q <= {tile.inst_w[3:1], load_fwd};

         if (inst_exec) begin
            if (inst_os) begin
               // Output-stationary MAC; the weight continues south.
               acc_q   <= os_sum_d;
               out_s_q <= wt_os_p;
               state_q <= S_OS_ACC;
            end else begin
               // Weight-stationary MAC, or pass-through without a weight.
               // The accumulator is left alone so an OS pass can resume.
               if (state_q == S_LOADED) begin
                  out_s_q <= ws_sum_d;
               end else begin
                  out_s_q <= tile.in_n;
               end
               if (state_q == S_OS_DRAIN) begin
                  state_q <= S_EMPTY;
               end
            end
         end else if (inst_drain) begin
            if (!inst_os) begin
               // Weight clear.
               b_q     <= '0;
               state_q <= S_EMPTY;
            end else begin
               case (state_q)
                  S_OS_ACC: begin
                     out_s_q <= acc_q;
                     acc_q   <= '0;
                     state_q <= S_OS_DRAIN;
                  end
                  S_OS_DRAIN: begin
                     out_s_q <= tile.in_n;
                  end
                  default: begin
                     // Nothing accumulated: emit nothing, out_s holds.
                  end
               endcase
            end
         end else if (inst_load) begin
            if (load_consume) begin
               b_q     <= tile.in_w;
               state_q <= S_LOADED;
            end
         end else if (state_q == S_OS_DRAIN) begin
            state_q <= S_EMPTY;
         end
      end
   end

   assign tile.out_s  = out_s_q;
   assign tile.out_e  = out_e_q;
   assign tile.inst_e = inst_e_q;

endmodule

// File: tb/tb_mac_tile_dual.sv
// Bench for mac_tile_dual: three tiles (16-bit wrap, 8-bit clamp, 8-bit wrap)
// receive identical stimulus; directed scenarios plus a randomized run scored
// against an integer reference model of the tile behaviour.
module tb_mac_tile_dual;

   logic clk;
   logic reset;

   int errors = 0;
   int checks = 0;
   int txn    = 0;

   mac_tile_dual_if #(.bw(4), .psum_bw(16)) if16 ();
   mac_tile_dual_if #(.bw(4), .psum_bw(8))  if8s ();
   mac_tile_dual_if #(.bw(4), .psum_bw(8))  if8w ();

   mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) u16  (.clk(clk), .reset(reset), .tile(if16));
   mac_tile_dual #(.bw(4), .psum_bw(8),  .SAT(1)) u8s  (.clk(clk), .reset(reset), .tile(if8s));
   mac_tile_dual #(.bw(4), .psum_bw(8),  .SAT(0)) u8w  (.clk(clk), .reset(reset), .tile(if8w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Tile k: 0 -> 16-bit wrap, 1 -> 8-bit clamp, 2 -> 8-bit wrap.
   // Mode: 0 empty, 1 weight loaded, 2 accumulating, 3 draining.
   int mmode [3];
   int mb    [3];
   int macc  [3];
   int mout  [3];
   logic [3:0] exp_ie;
   int         exp_oe;

   function automatic int pw(input int k);
      return (k == 0) ? 16 : 8;
   endfunction

   function automatic int wrapv(input int v, input int p);
      int m;
      int h;
      int r;
      m = 1 << p;
      h = 1 << (p - 1);
      r = (v + h) % m;
      if (r < 0) r = r + m;
      return r - h;
   endfunction

   function automatic int addp(input int a, input int b, input int k);
      int s;
      int h;
      s = a + b;
      h = 1 << (pw(k) - 1);
      if (k == 1) begin
         if (s > h - 1) return h - 1;
         if (s < -h) return -h;
         return s;
      end
      return wrapv(s, pw(k));
   endfunction

   function automatic int low4(input int n);
      int v;
      v = n & 15;
      if (v >= 8) v = v - 16;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mmode[k] = 0;
         mb[k]    = 0;
         macc[k]  = 0;
         mout[k]  = 0;
      end
      exp_ie = 4'b0;
      exp_oe = 0;
   endtask

   task automatic model_apply(input logic [3:0] inst, input int w, input int n);
      logic ld, ex, os, dr;
      int nk;
      int wt;
      ld = inst[0];
      ex = inst[1];
      os = inst[2];
      dr = inst[3];
      exp_oe = w;
      // Load is used only when it wins and the tile holds no weight.
      exp_ie = {inst[3:1], ld && !(!ex && !dr && (mmode[0] == 0 || mmode[0] == 3))};
      for (int k = 0; k < 3; k++) begin
         nk = wrapv(n, pw(k));
         if (ex) begin
            if (os) begin
               wt = low4(n);
               macc[k]  = addp((mmode[k] == 3) ? 0 : macc[k], w * wt, k);
               mout[k]  = wt;
               mmode[k] = 2;
            end else begin
               mout[k] = (mmode[k] == 1) ? addp(nk, w * mb[k], k) : nk;
               if (mmode[k] == 3) mmode[k] = 0;
            end
         end else if (dr) begin
            if (!os) begin
               mb[k]    = 0;
               mmode[k] = 0;
            end else if (mmode[k] == 2) begin
               mout[k]  = macc[k];
               macc[k]  = 0;
               mmode[k] = 3;
            end else if (mmode[k] == 3) begin
               mout[k] = nk;
            end
         end else if (ld) begin
            if (mmode[k] == 0 || mmode[k] == 3) begin
               mb[k]    = w;
               mmode[k] = 1;
            end
         end else if (mmode[k] == 3) begin
            mmode[k] = 0;
         end
      end
   endtask

   // One clock of stimulus to all tiles; outputs are valid on return (#1 after edge).
   task automatic step(input logic [3:0] inst, input int w, input int n);
      if16.inst_w = inst;  if16.in_w = 4'(w);  if16.in_n = 16'(n);
      if8s.inst_w = inst;  if8s.in_w = 4'(w);  if8s.in_n = 8'(n);
      if8w.inst_w = inst;  if8w.in_w = 4'(w);  if8w.in_n = 8'(n);
      model_apply(inst, w, n);
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d inst=%b in_w=%0d in_n=%0d -> out_s16=%0d out_s8s=%0d out_s8w=%0d out_e=%0d inst_e=%b",
               txn, inst, w, n, int'(if16.out_s), int'(if8s.out_s), int'(if8w.out_s),
               int'(if16.out_e), if16.inst_e);
   endtask

   task automatic apply_async_reset();
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0;
      step_idle_inputs();
      #3;
      checks++; if (if16.out_s !== 16'sd0) begin errors++; $display("FAIL reset_out_s got=%0d exp=0", int'(if16.out_s)); end
      checks++; if (if16.out_e !== 4'sd0) begin errors++; $display("FAIL reset_out_e got=%0d exp=0", int'(if16.out_e)); end
      checks++; if (if16.inst_e !== 4'b0) begin errors++; $display("FAIL reset_inst_e got=%b exp=0000", if16.inst_e); end
      checks++; if (if8s.out_s !== 8'sd0) begin errors++; $display("FAIL reset_out_s8 got=%0d exp=0", int'(if8s.out_s)); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic step_idle_inputs();
      if16.inst_w = 4'b0; if16.in_w = '0; if16.in_n = '0;
      if8s.inst_w = 4'b0; if8s.in_w = '0; if8s.in_n = '0;
      if8w.inst_w = 4'b0; if8w.in_w = '0; if8w.in_n = '0;
   endtask

   task automatic test_ws_mac();
      step(4'b0001, -2, 0);
      checks++; if (if16.inst_e !== 4'b0000) begin errors++; $display("FAIL ws_load_inst_e got=%b exp=0000", if16.inst_e); end
      step(4'b0010, 3, 10);
      checks++; if (int'(if16.out_s) !== 4) begin errors++; $display("FAIL ws_mac_out_s got=%0d exp=4", int'(if16.out_s)); end
      step(4'b0010, -8, -100);
      checks++; if (int'(if16.out_s) !== -84) begin errors++; $display("FAIL ws_mac_neg_out_s got=%0d exp=-84", int'(if16.out_s)); end
      step(4'b1000, 0, 0);
   endtask

   task automatic test_load_chain();
      step(4'b0001, 5, 0);
      checks++; if (if16.inst_e[0] !== 1'b0) begin errors++; $display("FAIL chain_inst_e0_first got=%b exp=0", if16.inst_e[0]); end
      checks++; if (int'(if16.out_e) !== 5) begin errors++; $display("FAIL chain_out_e_first got=%0d exp=5", int'(if16.out_e)); end
      step(4'b0001, 7, 0);
      checks++; if (if16.inst_e[0] !== 1'b1) begin errors++; $display("FAIL chain_inst_e0_second got=%b exp=1", if16.inst_e[0]); end
      checks++; if (int'(if16.out_e) !== 7) begin errors++; $display("FAIL chain_out_e_second got=%0d exp=7", int'(if16.out_e)); end
      step(4'b0010, 1, 0);
      checks++; if (int'(if16.out_s) !== 5) begin errors++; $display("FAIL chain_held_weight got=%0d exp=5", int'(if16.out_s)); end
      step(4'b1000, 0, 0);
      checks++; if (if16.inst_e !== 4'b1000) begin errors++; $display("FAIL wclr_propagate got=%b exp=1000", if16.inst_e); end
   endtask

   task automatic test_os_acc_drain();
      step(4'b0110, 2, 3);
      checks++; if (int'(if16.out_s) !== 3) begin errors++; $display("FAIL os_weight_south got=%0d exp=3", int'(if16.out_s)); end
      step(4'b0110, -1, 4);
      step(4'b0110, 7, -8);
      checks++; if (int'(if16.out_s) !== -8) begin errors++; $display("FAIL os_weight_south_neg got=%0d exp=-8", int'(if16.out_s)); end
      step(4'b0000, 0, 0);
      checks++; if (int'(if16.out_s) !== -8) begin errors++; $display("FAIL os_hold got=%0d exp=-8", int'(if16.out_s)); end
      step(4'b1100, 0, 0);
      checks++; if (int'(if16.out_s) !== -54) begin errors++; $display("FAIL os_drain got=%0d exp=-54", int'(if16.out_s)); end
      step(4'b1100, 0, 99);
      checks++; if (int'(if16.out_s) !== 99) begin errors++; $display("FAIL os_chain_drain got=%0d exp=99", int'(if16.out_s)); end
      // A new pass must start from zero, proving the drain cleared acc.
      step(4'b0110, 1, 1);
      step(4'b1100, 0, 0);
      checks++; if (int'(if16.out_s) !== 1) begin errors++; $display("FAIL os_acc_restart got=%0d exp=1", int'(if16.out_s)); end
      step(4'b0000, 0, 0);
   endtask

   task automatic test_saturation();
      step(4'b0001, 7, 0);
      step(4'b0010, 7, 120);
      checks++; if (int'(if8s.out_s) !== 127) begin errors++; $display("FAIL sat_clamp got=%0d exp=127", int'(if8s.out_s)); end
      checks++; if (int'(if8w.out_s) !== -87) begin errors++; $display("FAIL sat_wrap got=%0d exp=-87", int'(if8w.out_s)); end
      checks++; if (int'(if16.out_s) !== 169) begin errors++; $display("FAIL sat_wide got=%0d exp=169", int'(if16.out_s)); end
      step(4'b0010, -7, -120);
      checks++; if (int'(if8s.out_s) !== -128) begin errors++; $display("FAIL sat_clamp_neg got=%0d exp=-128", int'(if8s.out_s)); end
      checks++; if (int'(if8w.out_s) !== 87) begin errors++; $display("FAIL sat_wrap_neg got=%0d exp=87", int'(if8w.out_s)); end
      step(4'b1000, 0, 0);
   endtask

   task automatic test_wclr_priority();
      step(4'b0001, 3, 0);
      step(4'b0011, 1, 0);
      checks++; if (int'(if16.out_s) !== 3) begin errors++; $display("FAIL prio_exec_over_load got=%0d exp=3", int'(if16.out_s)); end
      step(4'b0010, 2, 0);
      checks++; if (int'(if16.out_s) !== 6) begin errors++; $display("FAIL prio_weight_kept got=%0d exp=6", int'(if16.out_s)); end
      step(4'b1000, 0, 0);
      step(4'b0010, 4, 9);
      checks++; if (int'(if16.out_s) !== 9) begin errors++; $display("FAIL wclr_passthrough got=%0d exp=9", int'(if16.out_s)); end
   endtask

   task automatic test_async_reset();
      step(4'b0110, 3, 2);
      step(4'b0000, 5, 0);
      apply_async_reset();
      #1;
      checks++; if (if16.out_s !== 16'sd0) begin errors++; $display("FAIL async_out_s got=%0d exp=0", int'(if16.out_s)); end
      checks++; if (if16.out_e !== 4'sd0) begin errors++; $display("FAIL async_out_e got=%0d exp=0", int'(if16.out_e)); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(4'b1100, 0, 55);
      checks++; if (int'(if16.out_s) !== 0) begin errors++; $display("FAIL async_no_partial got=%0d exp=0", int'(if16.out_s)); end
      step(4'b0001, 6, 0);
      checks++; if (if16.inst_e !== 4'b0000) begin errors++; $display("FAIL post_reset_load got=%b exp=0000", if16.inst_e); end
      step(4'b1000, 0, 0);
   endtask

   task automatic test_random();
      logic [3:0] ops [7];
      logic [3:0] op;
      int w;
      int n;
      ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
      ops[4] = 4'b1100; ops[5] = 4'b1000; ops[6] = 4'b0011;
      for (int i = 0; i < 300; i++) begin
         op = ops[$urandom_range(0, 6)];
         w  = int'($urandom_range(0, 15)) - 8;
         if ($urandom_range(0, 1) == 1) n = int'($urandom_range(0, 255)) - 128;
         else n = int'($urandom_range(0, 65535)) - 32768;
         step(op, w, n);
         checks++; if (int'(if16.out_s) !== mout[0]) begin errors++; $display("FAIL rnd_out_s16 txn=%0d got=%0d exp=%0d", txn, int'(if16.out_s), mout[0]); end
         checks++; if (int'(if8s.out_s) !== mout[1]) begin errors++; $display("FAIL rnd_out_s8sat txn=%0d got=%0d exp=%0d", txn, int'(if8s.out_s), mout[1]); end
         checks++; if (int'(if8w.out_s) !== mout[2]) begin errors++; $display("FAIL rnd_out_s8wrap txn=%0d got=%0d exp=%0d", txn, int'(if8w.out_s), mout[2]); end
         checks++; if (int'(if16.out_e) !== exp_oe) begin errors++; $display("FAIL rnd_out_e txn=%0d got=%0d exp=%0d", txn, int'(if16.out_e), exp_oe); end
         checks++; if (if16.inst_e !== exp_ie) begin errors++; $display("FAIL rnd_inst_e txn=%0d got=%b exp=%b", txn, if16.inst_e, exp_ie); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ws_mac();
      test_load_chain();
      test_os_acc_drain();
      test_saturation();
      test_wclr_priority();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
